// File: rtl/fact_accel.sv
// Memory-mapped factorial responder: the CPU writes N, pulses GO, polls STATUS
// and reads n! from RESULT once done is set.
module fact_accel #(
    parameter int NMAX = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [1:0]  a,
    input  logic [31:0] wd,
    output logic [31:0] rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_N      = 2'd0;
    localparam logic [1:0] ADDR_GO     = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_RESULT = 2'd3;

    state_t      r_state;
    logic [3:0]  r_n;
    logic [3:0]  r_cnt;
    logic [31:0] r_prod;
    logic        r_done;
    logic        r_err;

    logic w_busy;
    logic w_wr_n;
    logic w_go;
    logic w_n_too_big;
    logic w_unused_wd;

    assign w_busy      = (r_state == CALC);
    assign w_wr_n      = we && (a == ADDR_N) && !w_busy;
    assign w_go        = we && (a == ADDR_GO) && wd[0] && !w_busy;
    assign w_n_too_big = int'(r_n) > NMAX;
    assign w_unused_wd = ^wd[31:4];

    // GO uses the N held before the edge; a same-cycle N write cannot occur
    // because only one register is addressed per bus cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_n     <= '0;
            r_cnt   <= '0;
            r_prod  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (w_wr_n) begin
                r_n <= wd[3:0];
            end
            case (r_state)
                IDLE, DONE: begin
                    if (w_go) begin
                        r_cnt <= r_n;
                        if (w_n_too_big) begin
                            r_state <= DONE;
                            r_prod  <= '0;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= CALC;
                            r_prod  <= 32'd1;
                            r_done  <= 1'b0;
                            r_err   <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    if (r_cnt > 4'd1) begin
                        r_prod <= r_prod * {28'b0, r_cnt};
                        r_cnt  <= r_cnt - 4'd1;
                    end else begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Partial products stay hidden until done is set.
    always_comb begin
        // NOTE: default assignment first so no path leaves rd unassigned (no latch).
        rd = '0;
        case (a)
            ADDR_N:      rd = {28'b0, r_n};
            ADDR_GO:     rd = {31'b0, w_busy};
            ADDR_STATUS: rd = {29'b0, w_busy, r_err, r_done};
            ADDR_RESULT: rd = r_done ? r_prod : 32'd0;
            default:     rd = '0;
        endcase
    end

endmodule

// File: tb/tb_fact_accel.sv
// Directed bench for fact_accel: each GO pushes the expected result, status and
// latency to a scoreboard that is popped and compared when done is observed.
module tb_fact_accel;

    logic        clk;
    logic        rst;
    logic        we;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] result;
        logic [31:0] status;
        int          lat;
    } exp_t;

    exp_t sb[$];

    fact_accel #(.NMAX(12)) dut (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .a   (a),
        .wd  (wd),
        .rd  (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        we = 1'b1;
        a  = addr;
        wd = data;
        tick();
        we = 1'b0;
        wd = '0;
    endtask

    task automatic expect_rd(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        a = addr;
        #1;
        n_vec++;
        assert (rd === exp) else begin
            n_err++;
            $error("FAIL %s: rd=0x%08h expected 0x%08h", tag, rd, exp);
        end
    endtask

    task automatic expect_int(input string tag, input int got, input int exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fact(input int n);
        logic [31:0] p = 32'd1;
        for (int k = 2; k <= n; k++) p = p * 32'(k);
        return p;
    endfunction

    // Write N then GO, and record what the model expects from this operation.
    task automatic go(input int n);
        exp_t e;
        wr(2'd0, 32'(n));
        wr(2'd1, 32'd1);
        if (n > 12) begin
            e.result = 32'd0;
            e.status = 32'h3;
            e.lat    = 0;
        end else begin
            e.result = fact(n);
            e.status = 32'h1;
            e.lat    = (n < 1) ? 1 : n;
        end
        sb.push_back(e);
    endtask

    // Poll STATUS until done (bounded), checking busy on every intermediate edge.
    task automatic wait_done(input string tag, input int start_edges);
        int   edges = start_edges;
        bit   seen  = 1'b0;
        exp_t e;
        for (int i = 0; i < 40; i++) begin
            a = 2'd2;
            #1;
            if (rd[0] === 1'b1) begin
                seen = 1'b1;
                break;
            end
            expect_rd({tag, "_busy"}, 2'd2, 32'h4);
            tick();
            edges++;
        end
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s_sb: scoreboard empty, expected 1 entry", tag);
            return;
        end
        e = sb.pop_front();
        if (!seen) begin
            n_vec++;
            n_err++;
            $error("FAIL %s_timeout: done=0 after %0d edges, expected done=1", tag, edges);
            return;
        end
        expect_int({tag, "_latency"}, edges, e.lat);
        expect_rd({tag, "_status"}, 2'd2, e.status);
        expect_rd({tag, "_result"}, 2'd3, e.result);
    endtask

    initial begin
        rst = 1'b1;
        we  = 1'b0;
        a   = 2'd0;
        wd  = '0;

        // Reset scenario
        tick();
        rst = 1'b0;
        expect_rd("rst_status", 2'd2, 32'h0);
        expect_rd("rst_result", 2'd3, 32'h0);
        expect_rd("rst_n",      2'd0, 32'h0);
        expect_rd("rst_go",     2'd1, 32'h0);

        // N=5: busy for the intermediate edges, done on the 5th edge with 120
        go(5);
        expect_rd("n5_go_busy", 2'd1, 32'h1);
        expect_rd("n5_result_hidden", 2'd3, 32'h0);
        wait_done("n5", 0);
        expect_rd("n5_go_idle", 2'd1, 32'h0);

        // Done is held while idle; GO with wd[0]=0 and writes to STATUS/RESULT ignored
        tick();
        tick();
        expect_rd("n5_hold", 2'd3, 32'd120);
        wr(2'd1, 32'h2);
        wr(2'd2, 32'h0);
        wr(2'd3, 32'h0);
        expect_rd("ign_status", 2'd2, 32'h1);
        expect_rd("ign_result", 2'd3, 32'd120);

        // N=0 and N=1: one edge, result 1
        go(0);
        wait_done("n0", 0);
        go(1);
        wait_done("n1", 0);

        // N=12 largest legal operand, then N=13 errors on the GO edge
        go(12);
        wait_done("n12", 0);
        go(13);
        wait_done("n13", 0);
        expect_rd("n13_nreg", 2'd0, 32'd13);

        // Recovery from error with a fresh GO
        go(4);
        wait_done("n4", 0);

        // Busy protection: N and GO writes during CALC are ignored
        go(10);
        tick();
        tick();
        wr(2'd0, 32'd2);
        wr(2'd1, 32'd1);
        expect_rd("busy_nreg", 2'd0, 32'd10);
        wait_done("n10", 4);

        // Reset priority over a simultaneous N write
        rst = 1'b1;
        wr(2'd0, 32'd7);
        rst = 1'b0;
        expect_rd("rstpri_n", 2'd0, 32'h0);

        // Reset mid-operation aborts with no completion
        go(8);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        expect_rd("abort_status", 2'd2, 32'h0);
        expect_rd("abort_result", 2'd3, 32'h0);
        tick();
        tick();
        expect_rd("abort_stays_idle", 2'd2, 32'h0);
        go(3);
        wait_done("n3", 0);

        expect_int("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fact_accel.md
FACT_ACCEL -- requirements
Module: fact_accel

Interface
REQ-001 The block SHALL have one parameter: NMAX, default 12, the largest accepted operand; any larger operand is an error.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port we, input, 1 bit: write enable from the CPU data-memory bus.
REQ-005 The block SHALL have port a, input, 2 bits: register select; 0=N, 1=GO, 2=STATUS, 3=RESULT.
REQ-006 The block SHALL have port wd, input, 32 bits: write data.
REQ-007 The block SHALL have port rd, output, 32 bits: read data, combinational from a and the current state.

Function
REQ-008 The block SHALL be a memory-mapped responder that computes n! for the CPU.
REQ-009 Register N SHALL be 4 bits: latched from wd[3:0] on a rising edge with we=1 and a=0, only in IDLE or DONE; such writes SHALL be ignored in CALC.
REQ-010 Writing GO (we=1, a=1, wd[0]=1) in IDLE or DONE SHALL start an operation: it clears done and err and latches cnt=N and prod=1.
REQ-011 The GO write in REQ-010 SHALL enter CALC when N<=NMAX.
REQ-012 When N>NMAX, the GO write in REQ-010 SHALL enter DONE with err=1, done=1 and prod=0 on that same edge.
REQ-013 GO writes with wd[0]=0 SHALL be ignored, and GO writes in CALC SHALL be ignored.
REQ-014 If N and GO are written on the same edge, the block SHALL use the N value held before that edge, since only one register is addressed per cycle.
REQ-015 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-016 In CALC with cnt>1, each edge SHALL do prod <= prod*cnt (low 32 bits) and cnt <= cnt-1.
REQ-017 In CALC with cnt<=1, the next edge SHALL enter DONE with done=1 and leave prod unchanged.
REQ-018 Latency: done SHALL be visible max(N,1) edges after the GO edge; for N=0 and N=1, prod SHALL stay 1.
REQ-019 DONE SHALL be held until reset or a new GO write.
REQ-020 A new GO write in DONE SHALL behave exactly as REQ-010 to REQ-012.
REQ-021 STATUS SHALL read {29'b0, busy, err, done}, where busy=1 only in CALC.
REQ-022 RESULT SHALL read prod when done=1, and 0 otherwise (no partial products visible).
REQ-023 A read of register N SHALL return {28'b0, N}.
REQ-024 A read of register GO SHALL return {31'b0, busy}.
REQ-025 Writes to STATUS and RESULT SHALL be ignored.
REQ-026 For any N<=NMAX=12, the product SHALL fit in 32 bits; overflow detection beyond REQ-012 is not required.

Reset
REQ-027 When rst=1 at a rising edge, the block SHALL enter IDLE with N=0, cnt=0, prod=0, done=0, err=0.
REQ-028 After that reset edge, STATUS and RESULT SHALL both read 0.
REQ-029 Reset SHALL take priority over any simultaneous bus write.
REQ-030 Reset mid-CALC SHALL abort the operation with no completion.

Verification
REQ-031 Scenario, reset: rst=1 for one edge -> STATUS=0x0 and RESULT=0x0; rd for a=0 is 0x0.
REQ-032 Scenario, N=5: write N=5, then GO=1 -> STATUS=0x4 for 4 edges; on the 5th edge STATUS=0x1 and RESULT=0x78 (120).
REQ-033 Scenario, N=0 and N=1: each followed by GO -> after exactly 1 edge STATUS=0x1 and RESULT=0x1.
REQ-034 Scenario, N=12: GO -> done at edge 12 and RESULT=0x1C8CFC00 (479001600); then N=13 and GO -> on the next edge STATUS=0x3 and RESULT=0x0.
REQ-035 Scenario, busy protection: N=10 and GO; on edge 3 write N=2 and GO again -> both ignored; done at edge 10 with RESULT=0x00375F00 (3628800).
REQ-036 Scenario, reset mid-operation: N=8 and GO; rst=1 at edge 4 -> STATUS=0x0 and RESULT=0x0; a new GO with N=3 then gives RESULT=0x6 after 3 edges.
